// File: rtl/conv_pkg.sv
// Shared definitions for the window streamer: default element width and the
// frame-tracking state encoding.
package conv_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // FILL: no window pending yet in this frame
  // RUN : windows being produced
  // LAST: the frame's final window is pending
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/window_streamer_line_buffer.sv
// One image row of delay: a DEPTH-deep shift register that advances once per
// accepted pixel, so o_data is the pixel one row above the incoming one.
// Contents are intentionally not reset.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Shift one element per accepted pixel; the oldest falls out the far end
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/window_streamer.sv
// Sliding F x F window generator over a raster-order pixel stream.
// Optional feature: define WINDOW_STREAMER_POS_EN to add win_row/win_col,
// the top-left coordinate of the window currently presented.
//
// Handshake: a pixel moves when pixel_valid && pixel_ready, a window moves
// when window_valid && window_ready. window/window_valid are registered and
// held while window_valid && !window_ready; pixel_ready is simply
// !window_valid || window_ready, so a stalled window stalls the pixel input.
module window_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       pixel_in,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  output logic [0:F*F*DATA_WIDTH-1]   window,
  output logic                        window_valid,
  input  logic                        window_ready,
  output logic                        frame_done,
`ifdef WINDOW_STREAMER_POS_EN
  output logic [$clog2(H)-1:0]        win_row,
  output logic [$clog2(H)-1:0]        win_col,
`endif
  output logic [1:0]                  dbg_state
);

  localparam int RW    = (H > 1) ? $clog2(H) : 1;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int WIN_W = F * F * DATA_WIDTH;

  localparam logic [RW-1:0] ROW_FIRST = RW'(F - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(F - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);

  state_t                r_state;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic                  r_window_valid;
  logic [0:WIN_W-1]      r_window;
  // The F-1 most recent columns of the window, column F-2 being the newest
  logic [DATA_WIDTH-1:0] r_sr [F][F-1];
`ifdef WINDOW_STREAMER_POS_EN
  logic [RW-1:0]         r_win_row;
  logic [RW-1:0]         r_win_col;
`endif

  logic [DATA_WIDTH-1:0] w_lb_out [F-1];
  logic [DATA_WIDTH-1:0] w_col [F];
  logic [0:WIN_W-1]      w_window_next;
  logic                  w_pix_xfer;
  logic                  w_win_xfer;
  logic                  w_eligible;
  logic                  w_last_pix;

  assign pixel_ready = !r_window_valid || window_ready;
  assign w_pix_xfer  = pixel_valid && pixel_ready;
  assign w_win_xfer  = r_window_valid && window_ready;
  assign w_eligible  = w_pix_xfer && (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
  assign w_last_pix  = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Cascade of row delays: buffer k outputs the pixel k+1 rows above
  for (genvar k = 0; k < F - 1; k++) begin : g_lb
    logic [DATA_WIDTH-1:0] w_lb_in;
    if (k == 0) begin : g_head
      assign w_lb_in = pixel_in;
    end else begin : g_chain
      assign w_lb_in = w_lb_out[k-1];
    end
    line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (W)
    ) u_lb (
      .i_clk  (clk),
      .i_en   (w_pix_xfer),
      .i_data (w_lb_in),
      .o_data (w_lb_out[k])
    );
  end

  // Newest window column: top row from the deepest buffer, bottom row is the live pixel
  always_comb begin
    for (int i = 0; i < F - 1; i++) begin
      w_col[i] = w_lb_out[F-2-i];
    end
    w_col[F-1] = pixel_in;
  end

  // Assemble the candidate window: stored columns on the left, new column on the right
  always_comb begin
    w_window_next = '0;
    for (int i = 0; i < F; i++) begin
      for (int j = 0; j < F - 1; j++) begin
        w_window_next[(i*F+j)*DATA_WIDTH +: DATA_WIDTH] = r_sr[i][j];
      end
      w_window_next[(i*F+F-1)*DATA_WIDTH +: DATA_WIDTH] = w_col[i];
    end
  end

  // Column history shifts on every accepted pixel; no reset needed
  always_ff @(posedge clk) begin
    if (w_pix_xfer) begin
      for (int i = 0; i < F; i++) begin
        for (int j = 0; j < F - 2; j++) begin
          r_sr[i][j] <= r_sr[i][j+1];
        end
        r_sr[i][F-2] <= w_col[i];
      end
    end
  end

  // Position counters, window register and its valid flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row          <= '0;
      r_col          <= '0;
      r_window_valid <= 1'b0;
      r_window       <= '0;
`ifdef WINDOW_STREAMER_POS_EN
      r_win_row      <= '0;
      r_win_col      <= '0;
`endif
    end else begin
      if (w_pix_xfer) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_eligible) begin
        r_window_valid <= 1'b1;
        r_window       <= w_window_next;
`ifdef WINDOW_STREAMER_POS_EN
        r_win_row      <= r_row - ROW_FIRST;
        r_win_col      <= RW'(r_col - COL_FIRST);
`endif
      end else if (w_win_xfer) begin
        r_window_valid <= 1'b0;
      end
    end
  end

  // Frame progress: waiting for the first window, producing, final window pending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      case (r_state)
        FILL:    if (w_eligible) r_state <= w_last_pix ? LAST : RUN;
        RUN:     if (w_eligible && w_last_pix) r_state <= LAST;
        LAST:    if (w_win_xfer) r_state <= FILL;
        default: r_state <= FILL;
      endcase
    end
  end

  assign window       = r_window;
  assign window_valid = r_window_valid;
  assign frame_done   = (r_state == LAST) && w_win_xfer;
  assign dbg_state    = r_state;
`ifdef WINDOW_STREAMER_POS_EN
  assign win_row      = r_win_row;
  assign win_col      = r_win_col;
`endif

endmodule

// File: tb/tb_window_streamer.sv
// Directed bench for window_streamer with H=W=6, F=3, 32-bit pixels whose
// value is r*6+c. Define WINDOW_STREAMER_POS_EN to also exercise win_row/win_col.
module tb_window_streamer;

  localparam int DW    = 32;
  localparam int HH    = 6;
  localparam int WW    = 6;
  localparam int FF    = 3;
  localparam int WIN_W = FF * FF * DW;
  localparam int NWIN  = (HH - FF + 1) * (WW - FF + 1);

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic [DW-1:0]    pixel_in     = '0;
  logic             pixel_valid  = 1'b0;
  logic             pixel_ready;
  logic [0:WIN_W-1] window;
  logic             window_valid;
  logic             window_ready = 1'b1;
  logic             frame_done;
  logic [1:0]       dbg_state;
`ifdef WINDOW_STREAMER_POS_EN
  logic [2:0]       win_row;
  logic [2:0]       win_col;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIN_W-1:0] exp_q[$];
  logic [WIN_W-1:0] got_q[$];
  logic [5:0]       pos_q[$];
  int done_cnt     = 0;
  int cyc_cnt      = 0;
  int pix14_cyc    = -1;
  int first_wv_cyc = -1;

  window_streamer #(
    .DATA_WIDTH (DW),
    .H          (HH),
    .W          (WW),
    .F          (FF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window       (window),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .frame_done   (frame_done),
`ifdef WINDOW_STREAMER_POS_EN
    .win_row      (win_row),
    .win_col      (win_col),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Monitor: record handshakes mid-cycle, the transfer lands on the next rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid && pixel_ready && pixel_in == 14 && pix14_cyc < 0) pix14_cyc = cyc_cnt;
      if (window_valid && first_wv_cyc < 0) first_wv_cyc = cyc_cnt;
      if (window_valid && window_ready) begin
        got_q.push_back(window);
`ifdef WINDOW_STREAMER_POS_EN
        pos_q.push_back({win_row, win_col});
`endif
      end
      if (frame_done) done_cnt++;
    end
  end

  // Model: window with top-left (tr,tc), element (0,0) most significant
  function automatic logic [WIN_W-1:0] exp_window(input int tr, input int tc);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int i = 0; i < FF; i++)
      for (int j = 0; j < FF; j++)
        v = {v[WIN_W-DW-1:0], DW'((tr + i) * WW + tc + j)};
    return v;
  endfunction

  function automatic void fill_exp(input int n_frames);
    for (int f = 0; f < n_frames; f++)
      for (int k = 0; k < NWIN; k++)
        exp_q.push_back(exp_window(k / (WW - FF + 1), k % (WW - FF + 1)));
  endfunction

  // Driver: reset for two cycles and clear the scoreboard
  task automatic do_reset();
    @(posedge clk); #1;
    reset        = 1'b1;
    pixel_valid  = 1'b0;
    window_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    pos_q.delete();
    done_cnt     = 0;
    pix14_cyc    = -1;
    first_wv_cyc = -1;
  endtask

  // Driver: stream pixels first..first+n-1; rdy_mode 0=hold low, 1=high, 2=random
  task automatic run_stream(input int first, input int n, input bit rnd_v,
                            input int rdy_mode, output bit timed_out);
    int idx;
    int cyc;
    idx = first;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      pixel_in     = DW'(idx % (HH * WW));
      pixel_valid  = (idx < first + n) && (!rnd_v || $urandom_range(0, 1) == 1);
      window_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
      @(negedge clk);
      if (pixel_valid && pixel_ready) idx++;
      cyc++;
      if (idx == first + n && (!window_valid || window_ready)) break;
      if (cyc >= 3000) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    if (rdy_mode != 0) begin
      window_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL reset_window_valid got %b exp 0", window_valid); end
    checks++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_pixel_ready got %b exp 1", pixel_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (window !== '0) begin errors++; $display("FAIL reset_window got %h exp 0", window); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_single_frame();
    bit to;
    do_reset();
    fill_exp(1);
    run_stream(0, HH * WW, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got 1 exp 0"); end
    checks++; if (first_wv_cyc !== pix14_cyc + 1) begin errors++; $display("FAIL single_latency got cycle %0d exp %0d", first_wv_cyc, pix14_cyc + 1); end
    checks++; if (got_q.size() !== NWIN) begin errors++; $display("FAIL single_count got %0d exp %0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size()) begin errors++; $display("FAIL single_win[%0d] got none exp %h", k, exp_q[k]); end
      else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_win[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_frame_done got %0d exp 1", done_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL single_end_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_stall();
    bit to;
    logic [WIN_W-1:0] first_win;
    do_reset();
    fill_exp(1);
    first_win = exp_window(0, 0);
    run_stream(0, 15, 1'b0, 0, to);
    checks++; if (to) begin errors++; $display("FAIL stall_prefill_timeout got 1 exp 0"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      pixel_valid  = 1'b1;
      pixel_in     = DW'(15);
      window_ready = 1'b0;
      @(negedge clk);
      checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL stall_pixel_ready[%0d] got %b exp 0", c, pixel_ready); end
      checks++; if (window_valid !== 1'b1) begin errors++; $display("FAIL stall_window_valid[%0d] got %b exp 1", c, window_valid); end
      checks++; if (window !== first_win) begin errors++; $display("FAIL stall_window[%0d] got %h exp %h", c, window, first_win); end
    end
    run_stream(15, HH * WW - 15, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
    checks++; if (got_q.size() !== NWIN) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size()) begin errors++; $display("FAIL stall_win[%0d] got none exp %h", k, exp_q[k]); end
      else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_win[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    fill_exp(1);
    run_stream(0, HH * WW, 1'b1, 2, to);
    checks++; if (to) begin errors++; $display("FAIL random_timeout got 1 exp 0"); end
    checks++; if (got_q.size() !== NWIN) begin errors++; $display("FAIL random_count got %0d exp %0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size()) begin errors++; $display("FAIL random_win[%0d] got none exp %h", k, exp_q[k]); end
      else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL random_win[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL random_frame_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    fill_exp(2);
    run_stream(0, 2 * HH * WW, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got 1 exp 0"); end
    checks++; if (got_q.size() !== 2 * NWIN) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), 2 * NWIN); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size()) begin errors++; $display("FAIL b2b_win[%0d] got none exp %h", k, exp_q[k]); end
      else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_win[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_frame_done got %0d exp 2", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    do_reset();
    run_stream(0, 20, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_prefix_timeout got 1 exp 0"); end
    // Pixel 20 produces a window that is left pending when reset hits
    @(posedge clk); #1;
    pixel_valid  = 1'b1;
    pixel_in     = DW'(20);
    window_ready = 1'b0;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    checks++; if (window_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending got %b exp 1", window_valid); end
    do_reset();
    fill_exp(1);
    @(negedge clk);
    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_cleared got %b exp 0", window_valid); end
    run_stream(0, HH * WW, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout got 1 exp 0"); end
    checks++; if (first_wv_cyc !== pix14_cyc + 1) begin errors++; $display("FAIL midrst_first_window got cycle %0d exp %0d", first_wv_cyc, pix14_cyc + 1); end
    checks++; if (got_q.size() !== NWIN) begin errors++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), NWIN); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size()) begin errors++; $display("FAIL midrst_win[%0d] got none exp %h", k, exp_q[k]); end
      else if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_win[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst_frame_done got %0d exp 1", done_cnt); end
  endtask

`ifdef WINDOW_STREAMER_POS_EN
  task automatic test_position();
    bit to;
    logic [5:0] exp_pos;
    do_reset();
    run_stream(0, HH * WW, 1'b0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL pos_timeout got 1 exp 0"); end
    checks++; if (pos_q.size() !== NWIN) begin errors++; $display("FAIL pos_count got %0d exp %0d", pos_q.size(), NWIN); end
    for (int k = 0; k < NWIN; k++) begin
      exp_pos = {3'(k / 4), 3'(k % 4)};
      checks++;
      if (k >= pos_q.size()) begin errors++; $display("FAIL pos[%0d] got none exp (%0d,%0d)", k, k / 4, k % 4); end
      else if (pos_q[k] !== exp_pos) begin errors++; $display("FAIL pos[%0d] got (%0d,%0d) exp (%0d,%0d)", k, pos_q[k][5:3], pos_q[k][2:0], k / 4, k % 4); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef WINDOW_STREAMER_POS_EN
    test_position();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
